// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run/single-step controller.
// The optional step counter is enabled by defining CPU_STEP_COUNT_EN.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } cpu_state_e;

   // 10 ms of stable key level at 50 MHz
   localparam logic [19:0] DEBOUNCE_CYCLES_DEF = 20'd500_000;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes an active-low push key, debounces it, and emits a one-cycle
// press pulse when the debounced level falls. Releases produce no event.
module button_debouncer
   import cpu_ctrl_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clock_in,
   input  logic reset,
   input  logic btn_n,
   output logic level,
   output logic press
);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic [19:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      // The counter only runs while the synced key disagrees with the accepted level
      if (sync2_q != level_q) begin
         if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
            level_d = sync2_q;
            press_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 20'd1;
         end
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Run/single-step controller: turns slow-clock rising edges into one-cycle
// cpu_en pulses. Define CPU_STEP_COUNT_EN to build the step_count counter.
module cpu_step_controller
   import cpu_ctrl_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int          CNT_W           = 16
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             slow_clk,
   input  logic             step_btn_n,
   input  logic             run_sw,
   input  logic             halt,
   output logic             cpu_en,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] step_count
);

   cpu_state_e state_q, state_d;
   logic       slow_q, slow_d;
   logic       run_s1_q, run_s1_d;
   logic       run_s2_q, run_s2_d;
   logic       cpu_en_q, cpu_en_d;
   logic       tick;
   logic       key_level;
   logic       press;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clock_in(clock_in),
      .reset   (reset),
      .btn_n   (step_btn_n),
      .level   (key_level),
      .press   (press)
   );

   // slow_q resets high so a divider that powers up high yields no tick
   assign tick = slow_clk & ~slow_q;

   always_comb begin
      slow_d   = slow_clk;
      run_s1_d = run_sw;
      run_s2_d = run_s1_q;
      state_d  = state_q;
      cpu_en_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (halt)                       state_d = HALT;
            else if (run_s2_q)              state_d = RUN;
            else if (press && !key_level)   state_d = STEP;
         end
         RUN: begin
            if (halt) begin
               state_d = HALT;
            end else begin
               // A tick coinciding with the switch dropping still fires
               cpu_en_d = tick;
               if (!run_s2_q) state_d = IDLE;
            end
         end
         STEP: begin
            if (halt) begin
               state_d = HALT;
            end else if (tick) begin
               cpu_en_d = 1'b1;
               state_d  = IDLE;
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q  <= IDLE;
         slow_q   <= 1'b1;
         run_s1_q <= 1'b0;
         run_s2_q <= 1'b0;
         cpu_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         slow_q   <= slow_d;
         run_s1_q <= run_s1_d;
         run_s2_q <= run_s2_d;
         cpu_en_q <= cpu_en_d;
      end
   end

   assign cpu_en  = cpu_en_q;
   assign running = (state_q == RUN);
   assign halted  = (state_q == HALT);

`ifdef CPU_STEP_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cpu_en_q) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock_in) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign step_count = cnt_q;
`else
   assign step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed vector table, corner-case
// sequences and randomized traffic against a cycle-level reference model.
module tb_cpu_step_controller;

  localparam int CNT_W = 4;
  localparam int DB    = 4;
`ifdef CPU_STEP_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clock_in   = 1'b0;
  logic             reset      = 1'b1;
  logic             slow_clk   = 1'b1;
  logic             step_btn_n = 1'b1;
  logic             run_sw     = 1'b0;
  logic             halt       = 1'b0;
  logic             cpu_en;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] step_count;

  cpu_step_controller #(
    .DEBOUNCE_CYCLES(20'd4),
    .CNT_W          (CNT_W)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .slow_clk  (slow_clk),
    .step_btn_n(step_btn_n),
    .run_sw    (run_sw),
    .halt      (halt),
    .cpu_en    (cpu_en),
    .running   (running),
    .halted    (halted),
    .step_count(step_count)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: mode 0 idle, 1 free-run, 2 waiting for a step tick, 3 halted
  int m_mode;
  bit m_en;
  int m_cnt;
  bit m_k1, m_k2;
  bit m_lvl;
  int m_diff_len;
  bit m_press;
  bit m_r1, m_r2;
  bit m_slow_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    bit tick, pr, rs;
    if (reset) begin
      m_mode = 0; m_en = 1'b0; m_cnt = 0;
      m_k1 = 1'b1; m_k2 = 1'b1; m_lvl = 1'b1; m_diff_len = 0; m_press = 1'b0;
      m_r1 = 1'b0; m_r2 = 1'b0; m_slow_prev = 1'b1;
      return;
    end
    m_cnt = (m_cnt + int'(m_en)) % (1 << CNT_W);
    tick = slow_clk && !m_slow_prev;
    m_slow_prev = slow_clk;
    pr = m_press;
    rs = m_r2;
    m_r2 = m_r1;
    m_r1 = run_sw;
    // key level is accepted after DB consecutive disagreeing synced samples
    m_press = 1'b0;
    if (m_k2 != m_lvl) begin
      m_diff_len++;
      if (m_diff_len == DB) begin
        m_lvl = m_k2;
        m_press = !m_k2;
        m_diff_len = 0;
      end
    end else begin
      m_diff_len = 0;
    end
    m_k2 = m_k1;
    m_k1 = step_btn_n;
    m_en = 1'b0;
    case (m_mode)
      0: if (halt) m_mode = 3; else if (rs) m_mode = 1; else if (pr) m_mode = 2;
      1: if (halt) m_mode = 3; else begin m_en = tick; if (!rs) m_mode = 0; end
      2: if (halt) m_mode = 3; else if (tick) begin m_en = 1'b1; m_mode = 0; end
      default: m_mode = 3;
    endcase
  endtask

  task automatic cyc(input bit r, input bit s, input bit b, input bit rw, input bit h);
    reset = r; slow_clk = s; step_btn_n = b; run_sw = rw; halt = h;
    @(posedge clock_in);
    #1;
    model_edge();
    check("model_cpu_en", cpu_en, m_en);
    check("model_running", running, m_mode == 1);
    check("model_halted", halted, m_mode == 3);
    check("model_step_count", step_count, CNT_ON ? m_cnt : 0);
    if (cpu_en) pulses++;
  endtask

  typedef struct {
    bit r, s, b, rw, h;
    bit e_en, e_run, e_halt;
  } vec_t;

  vec_t tbl[12];
  bit   s_r, s_b, s_s, s_rw, s_h;
  int   hold;

  initial begin
    // reset, enter RUN, one tick pulse, halt coincident with a tick, reset
    tbl[0]  = '{1,1,1,0,0, 0,0,0};
    tbl[1]  = '{0,1,1,0,0, 0,0,0};
    tbl[2]  = '{0,1,1,1,0, 0,0,0};
    tbl[3]  = '{0,1,1,1,0, 0,0,0};
    tbl[4]  = '{0,1,1,1,0, 0,1,0};
    tbl[5]  = '{0,0,1,1,0, 0,1,0};
    tbl[6]  = '{0,1,1,1,0, 1,1,0};
    tbl[7]  = '{0,0,1,1,0, 0,1,0};
    tbl[8]  = '{0,1,1,1,1, 0,0,1};
    tbl[9]  = '{0,0,1,1,0, 0,0,1};
    tbl[10] = '{0,1,0,1,0, 0,0,1};
    tbl[11] = '{1,1,1,0,0, 0,0,0};

    repeat (2) cyc(1, 1, 1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].rw, tbl[i].h);
      check("tbl_cpu_en", cpu_en, tbl[i].e_en);
      check("tbl_running", running, tbl[i].e_run);
      check("tbl_halted", halted, tbl[i].e_halt);
    end

    // no spurious activity after reset with slow_clk held high
    pulses = 0;
    repeat (20) cyc(0, 1, 1, 0, 0);
    check("idle_pulses", pulses, 0);
    check("idle_count", step_count, 0);
    check("idle_state", {running, halted}, 0);

    // free run: 5 slow_clk rises in 50 cycles
    cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(0, 1, 1, 1, 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) cyc(0, ((i / 5) % 2) == 1, 1, 1, 0);
    check("run_pulses", pulses, 5);
    check("run_count", step_count, CNT_ON ? 5 : 0);
    check("run_running", running, 1);

    // single step from a held key, then a short glitch that must be rejected
    cyc(1, 1, 1, 0, 0);
    repeat (10) cyc(0, 1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) cyc(0, ((i / 3) % 2) == 1, 1, 0, 0);
    check("step_pulses", pulses, 1);
    check("step_back_idle", {running, halted}, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (8) cyc(0, 1, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) cyc(0, ((i / 3) % 2) == 1, 1, 0, 0);
    check("glitch_pulses", pulses, 0);

    // halted controller ignores ticks and presses
    cyc(0, 1, 1, 0, 1);
    pulses = 0;
    for (int i = 0; i < 30; i++) cyc(0, ((i / 3) % 2) == 1, (i > 10), 1, 0);
    check("halt_pulses", pulses, 0);
    check("halt_held", halted, 1);

    // 16 pulses wrap a 4-bit counter
    cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 64; i++) begin
      cyc(0, (i % 4) >= 2, 1, 1, 0);
      if (i == 60) check("wrap_count_15", step_count, CNT_ON ? 15 : 0);
    end
    cyc(0, 0, 1, 1, 0);
    check("wrap_count_0", step_count, 0);

    // reset part-way through a debounce discards the press
    cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) cyc(0, ((i / 3) % 2) == 1, 1, 0, 0);
    check("rst_debounce_pulses", pulses, 0);
    check("rst_debounce_outs", {cpu_en, running, halted}, 0);
    check("rst_debounce_count", step_count, 0);

    // randomized traffic against the model
    s_b = 1'b1; s_s = 1'b1; s_rw = 1'b0; hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        s_b = ~s_b;
        hold = $urandom_range(1, 10);
      end
      hold--;
      if ($urandom_range(0, 2) == 0) s_s = ~s_s;
      if ($urandom_range(0, 39) == 0) s_rw = ~s_rw;
      s_h = ($urandom_range(0, 299) == 0);
      s_r = ($urandom_range(0, 199) == 0);
      cyc(s_r, s_s, s_b, s_rw, s_h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
